perm_addr_inv: RTL and testbench
================================

Name: perm_addr_inv

Overview:
Permutation inverter for the slice permutation network. It accepts a gather vector, where slice i reads from source slice src[i], and produces the equivalent scatter vector, where dst[src[i]] = i. The scatter vector feeds the butterfly address decoder that consumes destination addresses. The block also flags non-bijective input. It processes serially, one slice per cycle, to keep area low, and sits between the permutation-program fetch and the address decoder.

Parameters:
LOG2SLICES  4  log2 of slice count; legal range 2..6
SLICES  1<<LOG2SLICES  slice count (derived, not overridable)
SELW  2  width of the sideband select field, passed through unchanged

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
t_0_dat  in  SELW+SLICES*LOG2SLICES  {sel, src[SLICES-1..0]}; src[i] at [LOG2SLICES*(i+1)-1 : LOG2SLICES*i]; sel at top
t_0_req  in  1  input vector valid
t_0_ack  out  1  block ready to accept
i_0_dat  out  SELW+SLICES*LOG2SLICES  {sel, dst[SLICES-1..0]}; same packing as t_0_dat
i_0_err  out  1  input was not a permutation (duplicate source index); qualified by i_0_req
i_0_req  out  1  output vector valid
i_0_ack  in  1  downstream ready

Behaviour:
- Interface: one clock domain. Reset is asynchronous and active-high. A transfer occurs on a rising clk edge with req&&ack high on the same channel.
- States: IDLE, SCAN, EMIT.
- Handshake outputs (combinational from state only): t_0_ack = (state==IDLE); i_0_req = (state==EMIT).
- IDLE -> SCAN on t_0_req.
  - Capture src vector and sel.
  - Clear dst register to 0, seen bitmap to 0, dup flag to 0, cnt to 0.
- SCAN, one slice per cycle, with k = cnt and s = src[k]:
  - If seen[s]==0: dst[s] <= k; seen[s] <= 1.
  - If seen[s]==1: dup <= 1; dst[s] is not overwritten (first writer wins).
  - cnt <= cnt+1. When k==SLICES-1, go to EMIT after this update.
- EMIT: i_0_dat, i_0_err and i_0_req are held stable until i_0_ack. On i_0_ack go to IDLE.
- i_0_err = dup. A duplicate always implies at least one missing destination; missing dst entries read 0.
- Latency: input accepted at edge N; i_0_req is high in the cycle after edge N+SLICES, with outputs valid from edge N+SLICES+1. Throughput is one vector per SLICES+2 cycles with i_0_ack held high.
- No input is accepted while in SCAN or EMIT. t_0_dat is ignored outside IDLE.
- sel passes through bit-exact, with no interpretation.
- cnt is LOG2SLICES bits wide. The terminal test is on k==SLICES-1, never on wrap to 0.
- Reset asserted (any state, including mid-SCAN or EMIT):
  - state=IDLE; in-flight vector discarded.
  - i_0_req=0, i_0_dat=0, i_0_err=0, cnt=0, seen=0.
  - t_0_ack=0 while reset is high; t_0_ack=1 in the first cycle after deassertion.
- Every output is registered or decoded from state. There is no combinational path from t_0_* or i_0_ack to any output.

Decomposition:
- Shared package perm_pkg:
  - LOG2SLICES/SLICES constants and the slice_idx_t typedef (LOG2SLICES bits).
  - Field offset functions for the packed {sel, vec} layout; these are shared with the destination-address decoder.
  - State enum for perm_addr_inv.
- Sub-module perm_idx_dec: slice index to one-hot SLICES-bit decoder. It is used both for the seen[] lookup and for the dst write enable.

Test Plan:
1. SLICES=4, src={0,1,2,3} (slice 0..3), sel=2'b10, i_0_ack=1 -> dst={0,1,2,3}, sel=2'b10, err=0; i_0_req rises the cycle after edge N+4.
2. SLICES=4, src={1,2,3,0} -> dst={3,0,1,2}, err=0. Butterfly involution src[i]=i^2 -> dst={2,3,0,1}.
3. SLICES=4, src={0,0,2,3} -> err=1, dst={0,0,2,3} (dst[0]=0 from first writer, dst[1]=0 missing).
4. Backpressure: hold i_0_ack=0 for 5 cycles in EMIT -> i_0_dat/i_0_err/i_0_req constant, t_0_ack=0. Next vector is accepted only in the cycle after the i_0_ack edge.
5. Reset mid-SCAN at k=2 (SLICES=16) -> next cycle i_0_req=0, i_0_dat=0, t_0_ack=0. After release t_0_ack=1, and a fresh vector produces a correct result with no residue in seen[].
6. LOG2SLICES=4, random permutations back-to-back with i_0_ack=1 -> outputs match a reference inverse. Spacing is exactly 18 cycles; err=0 throughout.

Source files
------------

// File: rtl/perm_pkg.sv
// Shared definitions for the slice permutation network:
// slice index types, packed {sel, vec} field offsets and FSM states.
package perm_pkg;

    localparam int LOG2SLICES = 4;
    localparam int SLICES     = 1 << LOG2SLICES;

    typedef logic [LOG2SLICES-1:0] slice_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT
    } perm_state_t;

    // LSB of slice field idx inside a packed vector of lg-bit fields
    function automatic int fld_lsb(input int idx, input int lg);
        return idx * lg;
    endfunction

    // LSB of the sideband select field, which sits above all slice fields
    function automatic int sel_lsb(input int lg);
        return (1 << lg) * lg;
    endfunction

endpackage

// File: rtl/perm_idx_dec.sv
// Slice index to one-hot decoder.
// Drives both the seen[] lookup and the dst write enables.
module perm_idx_dec
    import perm_pkg::*;
#(
    parameter int LOG2SLICES = perm_pkg::LOG2SLICES
) (
    input  logic [LOG2SLICES-1:0]      idx_i,
    output logic [(1<<LOG2SLICES)-1:0] onehot_o
);

    // Single hot bit at the position named by idx_i
    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/perm_addr_inv.sv
// Serial gather-to-scatter permutation inverter: dst[src[i]] = i,
// one slice per cycle, with duplicate-source (non-bijective) flag.
module perm_addr_inv
    import perm_pkg::*;
#(
    parameter int LOG2SLICES = perm_pkg::LOG2SLICES,
    parameter int SELW       = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [SELW+(1<<LOG2SLICES)*LOG2SLICES-1:0] t_0_dat,
    input  logic                                    t_0_req,
    output logic                                    t_0_ack,
    output logic [SELW+(1<<LOG2SLICES)*LOG2SLICES-1:0] i_0_dat,
    output logic                                    i_0_err,
    output logic                                    i_0_req,
    input  logic                                    i_0_ack
);

    localparam int SLICES  = 1 << LOG2SLICES;
    localparam int VECW    = SLICES * LOG2SLICES;
    localparam int SEL_LSB = sel_lsb(LOG2SLICES);
    localparam logic [LOG2SLICES-1:0] LAST = LOG2SLICES'(SLICES - 1);

    perm_state_t             state_q;
    logic [LOG2SLICES-1:0]   cnt_q;
    logic [LOG2SLICES-1:0]   cnt_d;
    logic [VECW-1:0]         src_q;
    logic [VECW-1:0]         dst_q;
    logic [SELW-1:0]         sel_q;
    logic [SLICES-1:0]       seen_q;
    logic                    dup_q;

    logic [LOG2SLICES-1:0]   s_idx;
    logic [SLICES-1:0]       s_oh;
    logic [SLICES-1:0]       wr_en;
    logic                    hit;

    assign s_idx = src_q[fld_lsb(int'(cnt_q), LOG2SLICES) +: LOG2SLICES];
    assign cnt_d = cnt_q + 1'b1;

    perm_idx_dec #(
        .LOG2SLICES (LOG2SLICES)
    ) u_dec (
        .idx_i    (s_idx),
        .onehot_o (s_oh)
    );

    // First writer wins: only slots not yet seen take the current index
    assign hit   = |(s_oh & seen_q);
    assign wr_en = s_oh & ~seen_q;

    // FSM, scan datapath and registered results in one process
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            sel_q   <= '0;
            seen_q  <= '0;
            dup_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (t_0_req) begin
                        state_q <= ST_SCAN;
                        src_q   <= t_0_dat[VECW-1:0];
                        sel_q   <= t_0_dat[SEL_LSB +: SELW];
                        dst_q   <= '0;
                        seen_q  <= '0;
                        dup_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (hit) begin
                        dup_q <= 1'b1;
                    end
                    seen_q <= seen_q | s_oh;
                    for (int j = 0; j < SLICES; j++) begin
                        if (wr_en[j]) begin
                            dst_q[fld_lsb(j, LOG2SLICES) +: LOG2SLICES] <= cnt_q;
                        end
                    end
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST) begin
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (i_0_ack) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshakes decode from state only; ready is withheld during reset
    assign t_0_ack = (state_q == ST_IDLE) && !reset;
    assign i_0_req = (state_q == ST_EMIT);
    assign i_0_dat = {sel_q, dst_q};
    assign i_0_err = dup_q;

endmodule

// File: tb/tb_perm_addr_inv.sv
// Directed bench for perm_addr_inv: SLICES=4 vector table plus
// backpressure, mid-scan reset and back-to-back SLICES=16 sequences.
module tb_perm_addr_inv;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic [9:0]  t4_dat;
    logic        t4_req;
    logic        t4_ack;
    logic [9:0]  i4_dat;
    logic        i4_err;
    logic        i4_req;
    logic        i4_ack;

    logic [65:0] t16_dat;
    logic        t16_req;
    logic        t16_ack;
    logic [65:0] i16_dat;
    logic        i16_err;
    logic        i16_req;
    logic        i16_ack;

    perm_addr_inv #(
        .LOG2SLICES (2),
        .SELW       (2)
    ) u_d4 (
        .clk     (clk),
        .reset   (reset),
        .t_0_dat (t4_dat),
        .t_0_req (t4_req),
        .t_0_ack (t4_ack),
        .i_0_dat (i4_dat),
        .i_0_err (i4_err),
        .i_0_req (i4_req),
        .i_0_ack (i4_ack)
    );

    perm_addr_inv #(
        .LOG2SLICES (4),
        .SELW       (2)
    ) u_d16 (
        .clk     (clk),
        .reset   (reset),
        .t_0_dat (t16_dat),
        .t_0_req (t16_req),
        .t_0_ack (t16_ack),
        .i_0_dat (i16_dat),
        .i_0_err (i16_err),
        .i_0_req (i16_req),
        .i_0_ack (i16_ack)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [7:0] src;
        logic [7:0] dst;
        logic       err;
    } vec_t;

    vec_t tv[7];

    // One SLICES=4 transaction with i_0_ack held high
    task automatic run4(input vec_t v, input int idx);
        int n;
        chk($sformatf("v%0d_rdy", idx), 128'(t4_ack), 128'(1));
        t4_dat = {v.sel, v.src};
        t4_req = 1'b1;
        @(posedge clk); #1;
        t4_req = 1'b0;
        t4_dat = '0;
        n = 0;
        while (!i4_req && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("v%0d_lat", idx), 128'(n), 128'(4));
        chk($sformatf("v%0d_dat", idx), 128'(i4_dat), 128'({v.sel, v.dst}));
        chk($sformatf("v%0d_err", idx), 128'(i4_err), 128'(v.err));
        @(posedge clk); #1;
        chk($sformatf("v%0d_idle_ack", idx), 128'(t4_ack), 128'(1));
        chk($sformatf("v%0d_idle_req", idx), 128'(i4_req), 128'(0));
    endtask

    logic [65:0] exp_q[$];
    logic        mon_en = 1'b0;
    int          got_n  = 0;

    // Scoreboard for back-to-back SLICES=16 results
    always @(negedge clk) begin
        if (mon_en && i16_req) begin
            if (exp_q.size() == 0) begin
                chk("t6_extra", 128'(i16_req), 128'(0));
            end else begin
                chk("t6_dat", 128'(i16_dat), 128'(exp_q.pop_front()));
                chk("t6_err", 128'(i16_err), 128'(0));
                got_n++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int p[16];
        int j;
        int t;
        logic [63:0] srcv;
        logic [63:0] dstv;
        logic [1:0]  selv;
        time tacc;
        time tprev;

        tv[0] = '{2'b10, 8'hE4, 8'hE4, 1'b0};
        tv[1] = '{2'b01, 8'h39, 8'h93, 1'b0};
        tv[2] = '{2'b11, 8'h4E, 8'h4E, 1'b0};
        tv[3] = '{2'b00, 8'hE0, 8'hE0, 1'b1};
        tv[4] = '{2'b01, 8'h1B, 8'h1B, 1'b0};
        tv[5] = '{2'b10, 8'h00, 8'h00, 1'b1};
        tv[6] = '{2'b11, 8'h26, 8'h07, 1'b1};

        t4_dat  = '0;
        t4_req  = 1'b0;
        i4_ack  = 1'b1;
        t16_dat = '0;
        t16_req = 1'b0;
        i16_ack = 1'b1;
        tprev   = 0;

        @(posedge clk); #1;
        chk("rst_t_ack", 128'(t4_ack), 128'(0));
        chk("rst_i_req", 128'(i4_req), 128'(0));
        chk("rst_i_dat", 128'(i4_dat), 128'(0));
        chk("rst_i_err", 128'(i4_err), 128'(0));
        reset = 1'b0;
        #1;
        chk("rel_t_ack", 128'(t4_ack), 128'(1));
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run4(tv[i], i);
        end

        // Backpressure: results hold while i_0_ack is low
        i4_ack = 1'b0;
        t4_dat = {2'b01, 8'h39};
        t4_req = 1'b1;
        @(posedge clk); #1;
        t4_dat = {2'b11, 8'h4E};
        n = 0;
        while (!i4_req && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_lat", 128'(n), 128'(4));
        for (int c = 0; c < 5; c++) begin
            chk("bp_dat", 128'(i4_dat), 128'({2'b01, 8'h93}));
            chk("bp_err", 128'(i4_err), 128'(0));
            chk("bp_req", 128'(i4_req), 128'(1));
            chk("bp_t_ack", 128'(t4_ack), 128'(0));
            @(posedge clk); #1;
        end
        i4_ack = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_ack", 128'(t4_ack), 128'(1));
        chk("bp_rel_req", 128'(i4_req), 128'(0));
        @(posedge clk); #1;
        t4_req = 1'b0;
        n = 0;
        while (!i4_req && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp2_lat", 128'(n), 128'(4));
        chk("bp2_dat", 128'(i4_dat), 128'({2'b11, 8'h4E}));
        @(posedge clk); #1;

        // Reset in the middle of a SLICES=16 scan
        srcv = '0;
        for (int i = 0; i < 16; i++) begin
            srcv[i*4 +: 4] = 4'(15 - i);
        end
        t16_dat = {2'b01, srcv};
        t16_req = 1'b1;
        @(posedge clk); #1;
        t16_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mr_i_req", 128'(i16_req), 128'(0));
        chk("mr_i_dat", 128'(i16_dat), 128'(0));
        chk("mr_i_err", 128'(i16_err), 128'(0));
        chk("mr_t_ack", 128'(t16_ack), 128'(0));
        @(posedge clk); #1;
        chk("mr_t_ack2", 128'(t16_ack), 128'(0));
        reset = 1'b0;
        #1;
        chk("mr_rel_ack", 128'(t16_ack), 128'(1));
        for (int i = 0; i < 16; i++) begin
            srcv[i*4 +: 4] = 4'(i);
        end
        t16_dat = {2'b10, srcv};
        t16_req = 1'b1;
        @(posedge clk); #1;
        t16_req = 1'b0;
        n = 0;
        while (!i16_req && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mr_lat", 128'(n), 128'(16));
        chk("mr_dat", 128'(i16_dat), 128'({2'b10, srcv}));
        chk("mr_err", 128'(i16_err), 128'(0));
        @(posedge clk); #1;

        // Random permutations back to back
        mon_en = 1'b1;
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 16; i++) begin
                p[i] = i;
            end
            for (int i = 15; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                t = p[i];
                p[i] = p[j];
                p[j] = t;
            end
            srcv = '0;
            dstv = '0;
            for (int i = 0; i < 16; i++) begin
                srcv[i*4 +: 4]    = 4'(p[i]);
                dstv[p[i]*4 +: 4] = 4'(i);
            end
            selv = 2'($urandom_range(3, 0));
            t16_dat = {selv, srcv};
            t16_req = 1'b1;
            n = 0;
            while (!t16_ack && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("t6_rdy", 128'(t16_ack), 128'(1));
            @(posedge clk);
            tacc = $time;
            exp_q.push_back({selv, dstv});
            #1;
            if (v > 0) begin
                chk("t6_space", 128'(tacc - tprev), 128'(180));
            end
            tprev = tacc;
        end
        t16_req = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        chk("t6_count", 128'(got_n), 128'(8));
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
